// File: rtl/serial_negate_pkg.sv
// serial_negate_pkg
// Shared definitions for the serial negate arbiter: FSM state encoding and
// the default operand width.
package serial_negate_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder
// One-bit full adder. It is the only arithmetic element in the serial
// negator.
// Ports:
//   a, b  : addend bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_negate_arbiter.sv
// serial_negate_arbiter
// Two requesters share one bit-serial two's-complement negator. In IDLE a
// round-robin arbiter picks a requester. The accepted operand is inverted and
// then incremented one bit per cycle through a single full adder. The result
// is held in DONE until the consumer takes it.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   reqN_valid/data/ready  : operand handshake for requesters 0 and 1
//   out_valid/data/id/ovf  : result, owning requester, most-negative flag
//   out_ready              : consumer takes the result
//   busy                   : high whenever the FSM is not in IDLE
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for an operand; the arbiter's grant drives reqN_ready
// ST_RUN  | one result bit per cycle, WIDTH cycles in total
// ST_DONE | result presented on out_*; held until out_ready
module serial_negate_arbiter
    import serial_negate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             out_ovf,
    input  logic             out_ready,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [WIDTH-1:0] operand_sr;
    logic [WIDTH-1:0] result_sr;
    logic [CNT_W-1:0] bit_cnt;
    logic             carry;
    logic             cur_id;
    logic             cur_ovf;
    logic             last_served;

    logic             grant0;
    logic             grant1;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] next_result;
    logic             fa_sum;
    logic             fa_cout;

    // Round-robin: on a tie the requester that was not served last wins.
    // last_served resets to 1 so requester 0 wins the first tie.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_served);
        grant1 = req1_valid & (~req0_valid | ~last_served);
    end

    // rst_n is included so the readies are low while reset is asserted,
    // even before the first reset edge has cleared the state.
    assign req0_ready = rst_n & (state == ST_IDLE) & grant0;
    assign req1_ready = rst_n & (state == ST_IDLE) & grant1;
    assign busy       = (state != ST_IDLE);

    assign sel_data    = req1_ready ? req1_data : req0_data;
    assign next_result = {fa_sum, result_sr[WIDTH-1:1]};

    // -x = ~x + 1: the inverted operand is added to zero with a carry-in of 1,
    // LSB first.
    full_adder u_full_adder (
        .a    (operand_sr[0]),
        .b    (1'b0),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            operand_sr  <= '0;
            result_sr   <= '0;
            bit_cnt     <= '0;
            carry       <= 1'b0;
            cur_id      <= 1'b0;
            cur_ovf     <= 1'b0;
            last_served <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_id      <= 1'b0;
            out_ovf     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        operand_sr  <= ~sel_data;
                        carry       <= 1'b1;
                        bit_cnt     <= '0;
                        cur_id      <= req1_ready;
                        cur_ovf     <= (sel_data == MOST_NEG);
                        last_served <= req1_ready;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_sr  <= next_result;
                    operand_sr <= operand_sr >> 1;
                    carry      <= fa_cout;
                    bit_cnt    <= bit_cnt + 1'b1;
                    // The final carry-out is dropped; the result wraps modulo 2^WIDTH.
                    if (bit_cnt == LAST_BIT) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        out_data  <= next_result;
                        out_id    <= cur_id;
                        out_ovf   <= cur_ovf;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_negate_arbiter.sv
// tb_serial_negate_arbiter
// Self-checking bench for serial_negate_arbiter (WIDTH = 8): a table of
// single operations, hand-written multi-cycle sequences, and a randomized run
// compared against a transaction-level reference model.
module tb_serial_negate_arbiter;
    import serial_negate_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_id, out_ovf;
    logic         out_ready;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] got_data_q[$];
    logic         got_id_q[$];

    typedef struct {
        logic         who;
        logic [W-1:0] data;
        logic [W-1:0] res;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    serial_negate_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ovf    (out_ovf),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one operand from a single requester and wait for its result.
    task automatic single_op(input logic who, input logic [W-1:0] d,
                             output logic [W-1:0] rd, output logic rid,
                             output logic rovf, output int lat);
        @(negedge clk);
        out_ready = 1'b1;
        if (who) begin
            req1_valid = 1'b1;
            req1_data  = d;
        end else begin
            req0_valid = 1'b1;
            req0_data  = d;
        end
        #1;
        chk("accept_ready", who ? req1_ready : req0_ready, 1'b1);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            req0_data  = W'($urandom);
            req1_data  = W'($urandom);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        rd   = out_data;
        rid  = out_id;
        rovf = out_ovf;
    endtask

    // Both requesters held valid; collect the first n results.
    task automatic stream(input int n, input logic [W-1:0] d0, input logic [W-1:0] d1);
        got_data_q.delete();
        got_id_q.delete();
        for (int c = 0; c < 400 && got_id_q.size() < n; c++) begin
            @(negedge clk);
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_data  = d0;
            req1_data  = d1;
            out_ready  = 1'b1;
            #1;
            if (out_valid) begin
                got_data_q.push_back(out_data);
                got_id_q.push_back(out_id);
            end
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("stream_count", got_id_q.size(), n);
    endtask

    // Reference model state: transaction level, cycle-counted.
    int           m_phase;     // 0 idle, 1 computing, 2 result offered
    int           m_left;
    logic         m_last;
    logic [W-1:0] m_pend_data, m_out_data;
    logic         m_pend_id, m_out_id, m_pend_ovf, m_out_ovf;

    initial begin
        logic [W-1:0] rd;
        logic         rid, rovf;
        int           lat;
        int           vcnt;
        logic         g0, g1, v0, v1, ordy, rstb;
        logic [W-1:0] d0, d1, dsel;

        vecs[0] = '{who: 1'b0, data: 8'h05, res: 8'hFB, ovf: 1'b0};
        vecs[1] = '{who: 1'b0, data: 8'h00, res: 8'h00, ovf: 1'b0};
        vecs[2] = '{who: 1'b1, data: 8'h80, res: 8'h80, ovf: 1'b1};
        vecs[3] = '{who: 1'b0, data: 8'hFF, res: 8'h01, ovf: 1'b0};
        vecs[4] = '{who: 1'b1, data: 8'h7F, res: 8'h81, ovf: 1'b0};
        vecs[5] = '{who: 1'b1, data: 8'h01, res: 8'hFF, ovf: 1'b0};
        vecs[6] = '{who: 1'b0, data: 8'h7E, res: 8'h82, ovf: 1'b0};

        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 8'h11;
        req1_data  = 8'h22;
        out_ready  = 1'b0;

        // Reset state, with both requesters valid during reset.
        @(negedge clk);
        #1;
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_id", out_id, 1'b0);
        chk("rst_out_ovf", out_ovf, 1'b0);
        chk("rst_busy", busy, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;

        // Table of single operations (latency, result, id, ovf).
        for (int i = 0; i < 7; i++) begin
            single_op(vecs[i].who, vecs[i].data, rd, rid, rovf, lat);
            chk("vec_latency", lat, W + 1);
            chk("vec_data", rd, vecs[i].res);
            chk("vec_id", rid, vecs[i].who);
            chk("vec_ovf", rovf, vecs[i].ovf);
        end

        // Tie from reset: requester 0 first, then 1.
        do_reset();
        stream(2, 8'h01, 8'h02);
        if (got_id_q.size() == 2) begin
            chk("tie_first_data", got_data_q[0], 8'hFF);
            chk("tie_first_id", got_id_q[0], 1'b0);
            chk("tie_second_data", got_data_q[1], 8'hFE);
            chk("tie_second_id", got_id_q[1], 1'b1);
        end

        // Six back-to-back operations alternate requesters.
        do_reset();
        stream(6, 8'h10, 8'h20);
        for (int i = 0; i < got_id_q.size(); i++) begin
            chk("rr_id", got_id_q[i], (i % 2 == 1) ? 1'b1 : 1'b0);
            chk("rr_data", got_data_q[i], (i % 2 == 1) ? 8'hE0 : 8'hF0);
        end

        // Result held in DONE while out_ready is low.
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 8'h5A;
        out_ready  = 1'b0;
        #1;
        chk("hold_accept", req0_ready, 1'b1);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req0_valid = 1'b0;
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk("hold_latency", lat, W + 1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, 8'hA6);
            chk("hold_id", out_id, 1'b0);
            chk("hold_ready0", req0_ready, 1'b0);
            chk("hold_ready1", req1_ready, 1'b0);
            chk("hold_busy", busy, 1'b1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("done_exit_valid", out_valid, 1'b1);
        chk("done_exit_ready0", req0_ready, 1'b0);
        chk("done_exit_ready1", req1_ready, 1'b0);
        @(negedge clk);
        #1;
        chk("after_done_valid", out_valid, 1'b0);
        chk("after_done_busy", busy, 1'b0);
        chk("after_done_data", out_data, 8'hA6);
        chk("after_done_ready1", req1_ready, 1'b1);
        chk("after_done_ready0", req0_ready, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset during RUN cycle 4 aborts the operation.
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 8'h33;
        out_ready  = 1'b1;
        #1;
        chk("abort_accept", req0_ready, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req0_valid = 1'b0;
            #1;
            chk("abort_run_busy", busy, 1'b1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        rst_n = 1'b1;
        vcnt  = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) vcnt++;
        end
        chk("abort_never_presented", vcnt, 0);
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("abort_tie_ready0", req0_ready, 1'b1);
        chk("abort_tie_ready1", req1_ready, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Randomized run against the reference model.
        do_reset();
        m_phase    = 0;
        m_left     = 0;
        m_last     = 1'b1;
        m_out_data = '0;
        m_out_id   = 1'b0;
        m_out_ovf  = 1'b0;
        m_pend_data = '0;
        m_pend_id   = 1'b0;
        m_pend_ovf  = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            v0   = ($urandom_range(0, 99) < 40);
            v1   = ($urandom_range(0, 99) < 40);
            d0   = W'($urandom);
            d1   = W'($urandom);
            ordy = ($urandom_range(0, 99) < 50);
            rstb = ($urandom_range(0, 99) >= 2);
            req0_valid = v0;
            req1_valid = v1;
            req0_data  = d0;
            req1_data  = d1;
            out_ready  = ordy;
            rst_n      = rstb;
            #1;
            g0 = rstb && (m_phase == 0) && v0 && (!v1 || m_last);
            g1 = rstb && (m_phase == 0) && v1 && (!v0 || !m_last);
            chk("rnd_ready0", req0_ready, g0);
            chk("rnd_ready1", req1_ready, g1);
            chk("rnd_busy", busy, m_phase != 0);
            chk("rnd_out_valid", out_valid, m_phase == 2);
            chk("rnd_out_data", out_data, m_out_data);
            chk("rnd_out_id", out_id, m_out_id);
            chk("rnd_out_ovf", out_ovf, m_out_ovf);

            if (!rstb) begin
                m_phase    = 0;
                m_last     = 1'b1;
                m_out_data = '0;
                m_out_id   = 1'b0;
                m_out_ovf  = 1'b0;
            end else if (m_phase == 0) begin
                if (g0 || g1) begin
                    dsel        = g1 ? d1 : d0;
                    m_pend_data = W'(((1 << W) - int'(dsel)) % (1 << W));
                    m_pend_ovf  = (int'(dsel) == (1 << (W - 1)));
                    m_pend_id   = g1;
                    m_last      = g1;
                    m_left      = W;
                    m_phase     = 1;
                end
            end else if (m_phase == 1) begin
                m_left--;
                if (m_left == 0) begin
                    m_phase    = 2;
                    m_out_data = m_pend_data;
                    m_out_id   = m_pend_id;
                    m_out_ovf  = m_pend_ovf;
                end
            end else if (ordy) begin
                m_phase = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_negate_arbiter.md
SERIAL_NEGATE_ARBITER -- requirements
Module: serial_negate_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (>=2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 has an operand.
REQ-005 SHALL have port: req0_data  input  WIDTH  requester 0 operand.
REQ-006 SHALL have port: req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-007 SHALL have ports req1_valid, req1_data, req1_ready: identical to REQ-004..006, requester 1.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_data  output  WIDTH  two's complement of accepted operand.
REQ-010 SHALL have port: out_id  output  1  requester that owns result.
REQ-011 SHALL have port: out_ovf  output  1  operand was most-negative value (100..0).
REQ-012 SHALL have port: out_ready  input  1  consumer takes result.
REQ-013 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; one operation in flight at a time.
REQ-015 SHALL, in IDLE, grant: sole valid requester; both valid -> requester not served last (round-robin).
REQ-016 SHALL drive reqN_ready = (state==IDLE) & grant to N, combinationally; at most one ready high per cycle.
REQ-017 SHALL, on accept (valid & ready), load shift register with ~data, carry <= 1, bit counter <= 0, latch id and ovf, record id as last served, go to RUN.
REQ-018 SHALL, each RUN cycle, feed shift LSB as A, 0 as B, carry as Cin into one full_adder; shift sum into result MSB, shift operand right, carry <= Cout, counter++.
REQ-019 SHALL leave RUN for DONE after exactly WIDTH RUN cycles; final carry-out discarded.
REQ-020 SHALL, in DONE, hold out_valid=1 with stable out_data/out_id/out_ovf until out_ready; on out_ready go to IDLE.
REQ-021 SHALL give latency: accept in cycle T -> out_valid first high in cycle T+WIDTH+1.
REQ-022 SHALL NOT accept a new operand in a DONE cycle, even when out_ready is high (earliest next accept one cycle after DONE exits).
REQ-023 SHALL ignore valid/data outside the accept cycle; deasserting valid without handshake has no effect.
REQ-024 SHALL keep out_valid=0 outside DONE; out_data/out_id/out_ovf hold last result.
REQ-025 SHALL produce wrap results: 0 -> 0; 100..0 -> 100..0 with out_ovf=1; all-ones -> 00..01.

Reset
REQ-026 SHALL, on rst_n low at clock edge, force IDLE, out_valid=0, out_data=0, out_id=0, out_ovf=0, busy=0, last-served=1 (requester 0 wins first tie).
REQ-027 SHALL abort any RUN/DONE operation on reset; aborted result is never presented.
REQ-028 SHALL drive reqN_ready=0 while rst_n is low.

Structure
REQ-029 SHALL place FSM state encoding and default WIDTH in shared package serial_negate_pkg.
REQ-030 SHALL instantiate exactly one existing full_adder sub-module as the sole arithmetic element.
REQ-031 SHALL keep arbiter, counter, shift registers and FSM in this module, no further sub-modules.

Verification
REQ-032 SHALL check: req0 valid, data 0x05, out_ready=1 -> out_valid at T+9, out_data 0xFB, out_id 0, out_ovf 0.
REQ-033 SHALL check: both valid from reset, data0 0x01, data1 0x02 -> first result 0xFF id 0, second 0xFE id 1.
REQ-034 SHALL check: boundaries 0x00 -> 0x00; 0x80 -> 0x80 ovf 1; 0xFF -> 0x01; 0x7F -> 0x81.
REQ-035 SHALL check: out_ready low 5 cycles in DONE -> outputs stable, both readies 0, busy 1.
REQ-036 SHALL check: rst_n low at RUN cycle 4 -> next cycle IDLE, out_valid 0, busy 0; next accept goes to req0 on tie.
REQ-037 SHALL check: both requesters continuously valid for 6 operations -> ids alternate 0,1,0,1,0,1.
